// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-ALU path: FSM state encodings, default widths
// and the ALU opcode map used by the ALU, the rx/alu interface and the benches.
package uart_alu_pkg;

  localparam int NB_STATE      = 3;
  localparam int DEF_NB_DATA   = 8;
  localparam int DEF_NB_OPCODE = 6;

  typedef enum logic [NB_STATE-1:0] {
    ST_0_WAIT_A  = 3'd0,
    ST_1_WAIT_B  = 3'd1,
    ST_2_WAIT_OP = 3'd2,
    ST_3_COMPUTE = 3'd3,
    ST_4_SEND    = 3'd4,
    ST_5_WAIT_TX = 3'd5
  } state_e;

  localparam logic [DEF_NB_OPCODE-1:0] OP_ADD = 6'b100000;
  localparam logic [DEF_NB_OPCODE-1:0] OP_SUB = 6'b100010;
  localparam logic [DEF_NB_OPCODE-1:0] OP_AND = 6'b100100;
  localparam logic [DEF_NB_OPCODE-1:0] OP_OR  = 6'b100101;
  localparam logic [DEF_NB_OPCODE-1:0] OP_XOR = 6'b100110;
  localparam logic [DEF_NB_OPCODE-1:0] OP_SRA = 6'b000011;
  localparam logic [DEF_NB_OPCODE-1:0] OP_SRL = 6'b000010;
  localparam logic [DEF_NB_OPCODE-1:0] OP_NOR = 6'b100111;

  // States in which the inter-byte gap of a frame is being timed.
  function automatic logic is_frame_gap_state(input state_e st);
    return (st == ST_1_WAIT_B) || (st == ST_2_WAIT_OP);
  endfunction

endpackage

// File: rtl/rx_alu_interface_if.sv
// Bundle of the receiver, ALU and transmitter signals seen by rx_alu_interface.
interface rx_alu_interface_if
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA   = DEF_NB_DATA,
  parameter int NB_OPCODE = DEF_NB_OPCODE
);

  logic [NB_DATA-1:0]   i_rx_data;
  logic                 i_rx_done;
  logic [NB_DATA-1:0]   i_alu_result;
  logic                 i_tx_done;
  logic [NB_DATA-1:0]   o_data_a;
  logic [NB_DATA-1:0]   o_data_b;
  logic [NB_OPCODE-1:0] o_opcode;
  logic [NB_DATA-1:0]   o_tx_data;
  logic                 o_tx_start;
  logic                 o_timeout;
  logic                 o_overrun;

  modport slave (
    input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    output o_data_a, o_data_b, o_opcode, o_tx_data, o_tx_start, o_timeout, o_overrun
  );

  modport master (
    output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    input  o_data_a, o_data_b, o_opcode, o_tx_data, o_tx_start, o_timeout, o_overrun
  );

endinterface

// File: rtl/rx_alu_interface_timeout.sv
// Inter-byte gap counter: counts while enabled and flags the cycle in which the
// count sits at TIMEOUT_CYCLES-1; it restarts from zero after that cycle.
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int NB_TIMEOUT     = 20
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [NB_TIMEOUT-1:0] LAST_COUNT = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMEOUT-1:0] count;

  assign o_expired = i_enable && (count == LAST_COUNT);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      count <= '0;
    end else if (i_clear || o_expired) begin
      count <= '0;
    end else if (i_enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rx_alu_interface.sv
// Assembles operand A, operand B and opcode from the UART receiver, latches the
// ALU result and hands it to the UART transmitter with a start/done handshake.
module rx_alu_interface
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA        = DEF_NB_DATA,
  parameter int NB_OPCODE      = DEF_NB_OPCODE,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int NB_TIMEOUT     = 20
) (
  input  logic               i_clock,
  input  logic               i_reset,
  rx_alu_interface_if.slave  bus
);

  state_e             state;
  logic [NB_DATA-1:0] rx_byte;
  logic               cnt_clear;
  logic               cnt_enable;
  logic               cnt_expired;

  assign rx_byte    = bus.i_rx_data;
  assign cnt_enable = is_frame_gap_state(state);
  // Counter idles at zero outside the gap states, so entering WAIT_A clears it.
  assign cnt_clear  = !cnt_enable || bus.i_rx_done;

  frame_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .NB_TIMEOUT     (NB_TIMEOUT)
  ) u_timeout (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (cnt_clear),
    .i_enable  (cnt_enable),
    .o_expired (cnt_expired)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state          <= ST_0_WAIT_A;
      bus.o_data_a   <= '0;
      bus.o_data_b   <= '0;
      bus.o_opcode   <= '0;
      bus.o_tx_data  <= '0;
      bus.o_tx_start <= 1'b0;
      bus.o_timeout  <= 1'b0;
      bus.o_overrun  <= 1'b0;
    end else begin
      bus.o_tx_start <= 1'b0;
      bus.o_timeout  <= 1'b0;
      case (state)
        ST_0_WAIT_A: begin
          if (bus.i_rx_done) begin
            bus.o_data_a <= rx_byte;
            state        <= ST_1_WAIT_B;
          end
        end
        ST_1_WAIT_B: begin
          if (bus.i_rx_done) begin
            bus.o_data_b <= rx_byte;
            state        <= ST_2_WAIT_OP;
          end else if (cnt_expired) begin
            bus.o_timeout <= 1'b1;
            state         <= ST_0_WAIT_A;
          end
        end
        ST_2_WAIT_OP: begin
          if (bus.i_rx_done) begin
            bus.o_opcode <= rx_byte[NB_OPCODE-1:0];
            state        <= ST_3_COMPUTE;
          end else if (cnt_expired) begin
            bus.o_timeout <= 1'b1;
            state         <= ST_0_WAIT_A;
          end
        end
        ST_3_COMPUTE: begin
          bus.o_tx_data <= bus.i_alu_result;
          state         <= ST_4_SEND;
        end
        ST_4_SEND: begin
          bus.o_tx_start <= 1'b1;
          state          <= ST_5_WAIT_TX;
        end
        ST_5_WAIT_TX: begin
          if (bus.i_tx_done) begin
            state <= ST_0_WAIT_A;
          end
        end
        default: begin
          state <= ST_0_WAIT_A;
        end
      endcase
      // Bytes arriving while a result is in flight are dropped but remembered.
      if (bus.i_rx_done && (state inside {ST_3_COMPUTE, ST_4_SEND, ST_5_WAIT_TX})) begin
        bus.o_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_alu_interface.sv
// Directed bench for rx_alu_interface with a behavioural ALU and a transmitter
// model that answers o_tx_start with i_tx_done 20 cycles later.
module tb_rx_alu_interface;
  import uart_alu_pkg::*;

  logic i_clock;
  logic i_reset;

  int tests_run      = 0;
  int tests_failed   = 0;
  int cyc            = 0;
  int start_count    = 0;
  int start_cyc      = 0;
  int timeout_count  = 0;
  int timeout_cyc    = 0;
  int tx_done_count  = 0;

  rx_alu_interface_if #(.NB_DATA(8), .NB_OPCODE(6)) bus ();

  rx_alu_interface #(
    .NB_DATA        (8),
    .NB_OPCODE      (6),
    .TIMEOUT_CYCLES (50),
    .NB_TIMEOUT     (6)
  ) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return 8'($signed(a) >>> b);
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  always_comb bus.i_alu_result = alu_model(bus.o_data_a, bus.o_data_b, bus.o_opcode);

  always @(negedge i_clock) begin
    cyc++;
    if (bus.o_tx_start) begin
      start_count++;
      start_cyc = cyc;
    end
    if (bus.o_timeout) begin
      timeout_count++;
      timeout_cyc = cyc;
    end
    if (bus.i_tx_done) tx_done_count++;
  end

  initial begin
    bus.i_tx_done = 1'b0;
    forever begin
      @(negedge i_clock);
      if (bus.o_tx_start) begin
        repeat (19) @(posedge i_clock);
        #1 bus.i_tx_done = 1'b1;
        @(posedge i_clock);
        #1 bus.i_tx_done = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    bus.i_rx_data = data;
    bus.i_rx_done = 1'b1;
    @(posedge i_clock);
    #1;
    bus.i_rx_done = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " data_a"},   bus.o_data_a,   0);
    checkOutput({tag, " data_b"},   bus.o_data_b,   0);
    checkOutput({tag, " opcode"},   bus.o_opcode,   0);
    checkOutput({tag, " tx_data"},  bus.o_tx_data,  0);
    checkOutput({tag, " tx_start"}, bus.o_tx_start, 0);
    checkOutput({tag, " timeout"},  bus.o_timeout,  0);
    checkOutput({tag, " overrun"},  bus.o_overrun,  0);
  endtask

  // Sends the opcode byte and follows the result through the transmitter handshake.
  task automatic finishFrame(input logic [7:0] op, input logic [7:0] exp_tx,
                             input logic [5:0] exp_op, input bit inject, input string tag);
    int  c0, starts0, done0;
    bit  seen;
    starts0 = start_count;
    done0   = tx_done_count;
    applyStimulus(op);
    c0   = cyc;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge i_clock);
      #1;
      if (start_count != starts0) seen = 1'b1;
    end
    checkOutput({tag, " start seen"}, seen, 1);
    checkOutput({tag, " start latency"}, start_cyc - c0 - 1, 2);
    checkOutput({tag, " tx_data"}, bus.o_tx_data, exp_tx);
    checkOutput({tag, " opcode"}, bus.o_opcode, exp_op);
    if (inject) begin
      applyStimulus(8'hAA);
      checkOutput({tag, " overrun set"}, bus.o_overrun, 1);
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge i_clock);
      #1;
      if (tx_done_count != done0) seen = 1'b1;
    end
    checkOutput({tag, " tx_done seen"}, seen, 1);
    @(posedge i_clock);
    #1;
    checkOutput({tag, " back to WAIT_A"}, dut.state == ST_0_WAIT_A, 1);
    checkOutput({tag, " single start"}, start_count - starts0, 1);
  endtask

  task automatic runFrame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input logic [7:0] exp_tx, input string tag);
    applyStimulus(a);
    applyStimulus(b);
    finishFrame(op, exp_tx, op[5:0], 1'b0, tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0, t0, s0;
    i_reset       = 1'b0;
    bus.i_rx_data = 8'h00;
    bus.i_rx_done = 1'b0;
    repeat (3) @(posedge i_clock);
    #1;
    checkAllZero("reset");
    i_reset = 1'b1;
    @(posedge i_clock);
    #1;

    runFrame(8'h05, 8'h03, 8'h20, 8'h08, "add");
    runFrame(8'h10, 8'h20, 8'hE2, 8'hF0, "sub");

    // Counter reaches 49 at edge t+49; the registered pulse follows one edge later.
    t0 = timeout_count;
    s0 = start_count;
    applyStimulus(8'h07);
    c0 = cyc;
    repeat (60) @(negedge i_clock);
    #1;
    checkOutput("timeout pulses", timeout_count - t0, 1);
    checkOutput("timeout latency", timeout_cyc - c0 - 1, 50);
    checkOutput("timeout no start", start_count - s0, 0);
    checkOutput("timeout keeps A", bus.o_data_a, 8'h07);
    runFrame(8'h01, 8'h02, 8'h20, 8'h03, "after timeout");

    t0 = timeout_count;
    applyStimulus(8'h11);
    repeat (49) @(posedge i_clock);
    #1;
    applyStimulus(8'h22);
    checkOutput("tie captures B", bus.o_data_b, 8'h22);
    repeat (5) @(negedge i_clock);
    #1;
    checkOutput("tie no timeout", timeout_count - t0, 0);
    checkOutput("tie in WAIT_OP", dut.state == ST_2_WAIT_OP, 1);
    finishFrame(8'h20, 8'h33, 6'h20, 1'b0, "tie");

    applyStimulus(8'h05);
    applyStimulus(8'h06);
    finishFrame(8'h20, 8'h0B, 6'h20, 1'b1, "overrun frame");
    runFrame(8'h02, 8'h02, 8'h20, 8'h04, "post overrun");
    checkOutput("overrun sticky", bus.o_overrun, 1);

    applyStimulus(8'h09);
    applyStimulus(8'h0A);
    i_reset = 1'b0;
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    checkAllZero("mid reset");
    runFrame(8'h04, 8'h04, 8'h24, 8'h04, "after reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
